alu_pipe: RTL and testbench

- Pipelined, parametrised successor to the single-cycle Hack-style ALU.
- Same six control bits (zx, nx, zy, ny, f, no), restructured as a two-stage valid/ready pipeline with full backpressure.
- Adds signed overflow, carry-out and a pass-through tag, so the CPU core can keep several operations in flight and match results to requests.
- Sits between the decode/operand-fetch logic (slave side) and writeback (master side).

---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu_pipe_slice.sv | 39 +++
 rtl/alu_pipe.sv | 152 +++++++++++++++
 tb/tb_alu_pipe.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared types and constants for the pipelined Hack-style ALU
package alu_pkg;

  typedef struct packed {
    logic zx;
    logic nx;
    logic zy;
    logic ny;
    logic f;
    logic no;
  } alu_ctrl_t;

  typedef struct packed {
    logic zr;
    logic ng;
    logic of;
    logic cy;
  } alu_flags_t;

  localparam int ALU_LATENCY = 2;

endpackage

// File: rtl/alu_pipe_slice.sv
// rtl/alu_pipe_slice.sv - generic valid/ready register slice with full throughput
module alu_pipe_slice #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         vld_i,
  output logic         rdy_o,
  input  logic [W-1:0] data_i,
  output logic         vld_o,
  input  logic         rdy_i,
  output logic [W-1:0] data_o
);

  logic         vld_q, vld_d;
  logic [W-1:0] data_q;
  logic         load;

  // Load when empty or when the current entry leaves on this edge.
  assign load  = !vld_q || rdy_i;
  assign rdy_o = load;
  assign vld_d = load ? vld_i : vld_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_q  <= 1'b0;
      data_q <= '0;
    end else begin
      vld_q <= vld_d;
      if (load && vld_i) begin
        data_q <= data_i;
      end
    end
  end

  assign vld_o  = vld_q;
  assign data_o = data_q;

endmodule

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - two-stage valid/ready Hack ALU with overflow, carry and tag
// ALU_PIPE_SKID_EN adds a 2-entry output skid that cuts the rdy_m to rdy_s path.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int D_W   = 16,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             vld_s,
  output logic             rdy_s,
  input  logic [D_W-1:0]   x_s,
  input  logic [D_W-1:0]   y_s,
  input  logic             zx_s,
  input  logic             nx_s,
  input  logic             zy_s,
  input  logic             ny_s,
  input  logic             f_s,
  input  logic             no_s,
  input  logic [TAG_W-1:0] tag_s,
  output logic             vld_m,
  input  logic             rdy_m,
  output logic [D_W-1:0]   out_m,
  output logic             zr_m,
  output logic             ng_m,
  output logic             of_m,
  output logic             cy_m,
  output logic [TAG_W-1:0] tag_m
);

  localparam int S1_W = 2*D_W + 2 + TAG_W;
  localparam int S2_W = D_W + 4 + TAG_W;

  alu_ctrl_t      ctrl;
  logic [D_W-1:0] xz, yz, a_s, b_s;

  assign ctrl = {zx_s, nx_s, zy_s, ny_s, f_s, no_s};
  assign xz   = ctrl.zx ? '0 : x_s;
  assign yz   = ctrl.zy ? '0 : y_s;
  assign a_s  = ctrl.nx ? ~xz : xz;
  assign b_s  = ctrl.ny ? ~yz : yz;

  logic             s1_vld, s1_rdy_dn;
  logic [S1_W-1:0]  s1_data;
  logic [D_W-1:0]   a1, b1;
  logic             f1, no1;
  logic [TAG_W-1:0] tag1;

  alu_pipe_slice #(.W(S1_W)) u_s1 (
    .clk    (clk),
    .rstn   (rstn),
    .vld_i  (vld_s),
    .rdy_o  (rdy_s),
    .data_i ({a_s, b_s, ctrl.f, ctrl.no, tag_s}),
    .vld_o  (s1_vld),
    .rdy_i  (s1_rdy_dn),
    .data_o (s1_data)
  );

  assign {a1, b1, f1, no1, tag1} = s1_data;

  logic [D_W:0]   sum;
  logic [D_W-1:0] calc, res;
  alu_flags_t     flags;

  // Overflow and carry describe the raw sum, before the optional output inversion.
  assign sum      = {1'b0, a1} + {1'b0, b1};
  assign calc     = f1 ? sum[D_W-1:0] : (a1 & b1);
  assign res      = no1 ? ~calc : calc;
  assign flags.zr = (res == '0);
  assign flags.ng = res[D_W-1];
  assign flags.of = f1 && (a1[D_W-1] == b1[D_W-1]) && (sum[D_W-1] != a1[D_W-1]);
  assign flags.cy = f1 && sum[D_W];

  logic            s2_vld, s2_rdy_dn;
  logic [S2_W-1:0] s2_data;

  alu_pipe_slice #(.W(S2_W)) u_s2 (
    .clk    (clk),
    .rstn   (rstn),
    .vld_i  (s1_vld),
    .rdy_o  (s1_rdy_dn),
    .data_i ({res, flags, tag1}),
    .vld_o  (s2_vld),
    .rdy_i  (s2_rdy_dn),
    .data_o (s2_data)
  );

  logic [S2_W-1:0] head_data;
  alu_flags_t      flags_m;

`ifdef ALU_PIPE_SKID_EN
  // k1 is the older skid entry and always fills before k0; an empty skid is bypassed.
  logic            s2_take, nf_q, nf_d;
  logic            k0_vld, k0_rdy, k0_in_vld;
  logic            k1_vld, k1_rdy, k1_in_vld;
  logic [S2_W-1:0] k0_data, k1_data, k1_in_data;

  assign s2_rdy_dn  = nf_q;
  assign s2_take    = s2_vld && nf_q;
  assign k1_in_vld  = k0_vld || (s2_take && (k1_vld || !rdy_m));
  assign k1_in_data = k0_vld ? k0_data : s2_data;
  assign k0_in_vld  = s2_take && k1_vld && !rdy_m;

  alu_pipe_slice #(.W(S2_W)) u_k1 (
    .clk    (clk),
    .rstn   (rstn),
    .vld_i  (k1_in_vld),
    .rdy_o  (k1_rdy),
    .data_i (k1_in_data),
    .vld_o  (k1_vld),
    .rdy_i  (rdy_m),
    .data_o (k1_data)
  );

  alu_pipe_slice #(.W(S2_W)) u_k0 (
    .clk    (clk),
    .rstn   (rstn),
    .vld_i  (k0_in_vld),
    .rdy_o  (k0_rdy),
    .data_i (s2_data),
    .vld_o  (k0_vld),
    .rdy_i  (k1_rdy),
    .data_o (k0_data)
  );

  assign nf_d = !(k0_rdy ? k0_in_vld : k0_vld);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      nf_q <= 1'b1;
    end else begin
      nf_q <= nf_d;
    end
  end

  assign vld_m     = k1_vld || s2_vld;
  assign head_data = k1_vld ? k1_data : s2_data;
`else
  assign s2_rdy_dn = rdy_m;
  assign vld_m     = s2_vld;
  assign head_data = s2_data;
`endif

  assign {out_m, flags_m, tag_m} = head_data;
  assign zr_m = flags_m.zr;
  assign ng_m = flags_m.ng;
  assign of_m = flags_m.of;
  assign cy_m = flags_m.cy;

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - self-checking bench for alu_pipe with an arithmetic reference model
module tb_alu_pipe;

  localparam int D_W   = 16;
  localparam int TAG_W = 4;
`ifdef ALU_PIPE_SKID_EN
  localparam int CAP = 4;
`else
  localparam int CAP = 2;
`endif

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [5:0]  c;
    logic [3:0]  tag;
  } vec_t;

  typedef struct packed {
    logic [15:0] out;
    logic        zr;
    logic        ng;
    logic        of;
    logic        cy;
    logic [3:0]  tag;
  } exp_t;

  logic             clk = 1'b0;
  logic             rstn;
  logic             vld_s, rdy_s;
  logic [D_W-1:0]   x_s, y_s;
  logic             zx_s, nx_s, zy_s, ny_s, f_s, no_s;
  logic [TAG_W-1:0] tag_s;
  logic             vld_m, rdy_m;
  logic [D_W-1:0]   out_m;
  logic             zr_m, ng_m, of_m, cy_m;
  logic [TAG_W-1:0] tag_m;

  int n_checks = 0;
  int n_errors = 0;
  exp_t q[$];

  alu_pipe #(.D_W(D_W), .TAG_W(TAG_W)) dut (
    .clk   (clk),
    .rstn  (rstn),
    .vld_s (vld_s),
    .rdy_s (rdy_s),
    .x_s   (x_s),
    .y_s   (y_s),
    .zx_s  (zx_s),
    .nx_s  (nx_s),
    .zy_s  (zy_s),
    .ny_s  (ny_s),
    .f_s   (f_s),
    .no_s  (no_s),
    .tag_s (tag_s),
    .vld_m (vld_m),
    .rdy_m (rdy_m),
    .out_m (out_m),
    .zr_m  (zr_m),
    .ng_m  (ng_m),
    .of_m  (of_m),
    .cy_m  (cy_m),
    .tag_m (tag_m)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input vec_t v);
    exp_t        e;
    logic [15:0] xv, yv, calc;
    int          us, ss;
    xv = v.c[5] ? 16'h0 : v.x;
    if (v.c[4]) xv = ~xv;
    yv = v.c[3] ? 16'h0 : v.y;
    if (v.c[2]) yv = ~yv;
    if (v.c[1]) begin
      us   = int'(xv) + int'(yv);
      ss   = int'($signed(xv)) + int'($signed(yv));
      calc = 16'(us);
      e.cy = (us > 65535);
      e.of = (ss > 32767) || (ss < -32768);
    end else begin
      calc = xv & yv;
      e.cy = 1'b0;
      e.of = 1'b0;
    end
    e.out = v.c[0] ? ~calc : calc;
    e.zr  = (e.out == 16'h0);
    e.ng  = e.out[15];
    e.tag = v.tag;
    return e;
  endfunction

  function automatic vec_t cur_vec();
    vec_t v;
    v.x   = x_s;
    v.y   = y_s;
    v.c   = {zx_s, nx_s, zy_s, ny_s, f_s, no_s};
    v.tag = tag_s;
    return v;
  endfunction

  task automatic set_op(input vec_t v);
    x_s = v.x;
    y_s = v.y;
    {zx_s, nx_s, zy_s, ny_s, f_s, no_s} = v.c;
    tag_s = v.tag;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard and hold-stability monitor, sampled on the falling edge.
  logic        held = 1'b0;
  logic [15:0] h_out;
  logic [3:0]  h_fl, h_tag;
  always @(negedge clk) begin
    if (!rstn) begin
      q.delete();
      held = 1'b0;
    end else begin
      if (vld_s && rdy_s) q.push_back(model(cur_vec()));
      if (vld_m && rdy_m) begin
        if (q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL rx_unexpected: got tag %0h, expected no result", tag_m);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("sb_out", 32'(out_m), 32'(e.out));
          check("sb_flags", 32'({zr_m, ng_m, of_m, cy_m}), 32'({e.zr, e.ng, e.of, e.cy}));
          check("sb_tag", 32'(tag_m), 32'(e.tag));
        end
      end
      if (vld_m && !rdy_m) begin
        if (held) begin
          check("hold_out", 32'(out_m), 32'(h_out));
          check("hold_flags", 32'({zr_m, ng_m, of_m, cy_m}), 32'(h_fl));
          check("hold_tag", 32'(tag_m), 32'(h_tag));
        end
        held  = 1'b1;
        h_out = out_m;
        h_fl  = {zr_m, ng_m, of_m, cy_m};
        h_tag = tag_m;
      end else begin
        held = 1'b0;
      end
    end
  end

  // Single op with rdy_m high: result visible in the second cycle after it is presented.
  task automatic run_lit(input string name, input vec_t v, input logic [15:0] eo,
                         input logic [3:0] ef);
    set_op(v);
    vld_s = 1'b1;
    rdy_m = 1'b1;
    @(negedge clk);
    check({name, "_rdy_s"}, 32'(rdy_s), 32'd1);
    tick();
    vld_s = 1'b0;
    check({name, "_early_vld"}, 32'(vld_m), 32'd0);
    tick();
    check({name, "_vld"}, 32'(vld_m), 32'd1);
    check({name, "_out"}, 32'(out_m), 32'(eo));
    check({name, "_flags"}, 32'({zr_m, ng_m, of_m, cy_m}), 32'(ef));
    check({name, "_tag"}, 32'(tag_m), 32'(v.tag));
    tick();
    check({name, "_drained"}, 32'(vld_m), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t bp[4];
    vec_t burst[12];
    int   idx, got, gaps;
    logic acc;

    rstn  = 1'b0;
    vld_s = 1'b0;
    rdy_m = 1'b0;
    set_op('0);
    repeat (3) tick();
    check("rst_vld_m", 32'(vld_m), 32'd0);
    check("rst_out_m", 32'(out_m), 32'd0);
    check("rst_flags", 32'({zr_m, ng_m, of_m, cy_m}), 32'd0);
    check("rst_tag_m", 32'(tag_m), 32'd0);
    rstn = 1'b1;
    tick();
    check("rst_rdy_s", 32'(rdy_s), 32'd1);

    // Hand-computed vectors; control order is {zx,nx,zy,ny,f,no}, flags {zr,ng,of,cy}.
    run_lit("add",    '{x:16'h0005, y:16'h0003, c:6'b000010, tag:4'h1}, 16'h0008, 4'b0000);
    run_lit("neg1",   '{x:16'h1234, y:16'h5678, c:6'b111010, tag:4'h2}, 16'hFFFF, 4'b0100);
    run_lit("ovf",    '{x:16'h7FFF, y:16'h0001, c:6'b000010, tag:4'h3}, 16'h8000, 4'b0110);
    run_lit("carry",  '{x:16'hFFFF, y:16'h0001, c:6'b000010, tag:4'h4}, 16'h0000, 4'b1001);
    run_lit("andneg", '{x:16'h00F0, y:16'h0FF0, c:6'b000001, tag:4'h5}, 16'hFF0F, 4'b0100);

    // Backpressure: outputs stalled for six cycles, then released.
    for (int i = 0; i < 4; i++) bp[i] = '{x:16'(i * 16'h1111), y:16'h0001, c:6'b000010, tag:4'(i)};
    idx   = 0;
    rdy_m = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (idx < 4) begin set_op(bp[idx]); vld_s = 1'b1; end else vld_s = 1'b0;
      @(negedge clk);
      acc = vld_s && rdy_s;
      tick();
      if (acc) idx++;
    end
    check("bp_accepts", 32'(idx), 32'(CAP));
    check("bp_rdy_s_low", 32'(rdy_s), 32'd0);
    rdy_m = 1'b1;
    got   = 0;
    gaps  = 0;
    for (int c = 0; c < 20 && got < 4; c++) begin
      if (idx < 4) begin set_op(bp[idx]); vld_s = 1'b1; end else vld_s = 1'b0;
      @(negedge clk);
      acc = vld_s && rdy_s;
      if (vld_m) begin
        check("bp_order", 32'(tag_m), 32'(got));
        got++;
      end else if (got > 0) begin
        gaps++;
      end
      tick();
      if (acc) idx++;
    end
    vld_s = 1'b0;
    check("bp_all_out", 32'(got), 32'd4);
    check("bp_no_gaps", 32'(gaps), 32'd0);

    // Mixed controls under an irregular rdy_m pattern, checked by the scoreboard.
    for (int i = 0; i < 12; i++)
      burst[i] = '{x:16'(i * 16'h3C5A + 16'h8001), y:16'(i * 16'h1F07 + 16'h7FF0),
                   c:6'(i * 11 + 2), tag:4'(i)};
    idx = 0;
    for (int c = 0; c < 200 && (idx < 12 || q.size() != 0); c++) begin
      rdy_m = ((c % 3) != 2);
      if (idx < 12) begin set_op(burst[idx]); vld_s = 1'b1; end else vld_s = 1'b0;
      @(negedge clk);
      acc = vld_s && rdy_s;
      tick();
      if (acc) idx++;
    end
    vld_s = 1'b0;
    check("burst_sent", 32'(idx), 32'd12);
    check("burst_drained", 32'(q.size()), 32'd0);

    // Reset with two operations in flight discards both.
    rdy_m = 1'b1;
    set_op('{x:16'h0101, y:16'h0202, c:6'b000010, tag:4'hA});
    vld_s = 1'b1;
    tick();
    set_op('{x:16'h0303, y:16'h0404, c:6'b000010, tag:4'hB});
    tick();
    vld_s = 1'b0;
    check("rst_pre_vld", 32'(vld_m), 32'd1);
    rstn = 1'b0;
    #1;
    check("rst_async_vld", 32'(vld_m), 32'd0);
    check("rst_async_out", 32'(out_m), 32'd0);
    check("rst_async_tag", 32'(tag_m), 32'd0);
    tick();
    tick();
    rstn = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("rst_no_ghost", 32'(vld_m), 32'd0);
    end
    check("final_queue_empty", 32'(q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
